divider_seq: RTL and testbench

- Parametrised multi-cycle restoring ("attempt-subtract") divider.
- Generational successor to the team's combinational divider: registered operands, one quotient bit per clock, start/busy/done handshake, divide-by-zero flag, optional signed mode.
- Intended for datapaths where the combinational array's depth breaks timing.

---
 rtl/divider_seq_if.sv | 13 +
 rtl/divider_seq.sv | 88 ++++++++
 tb/tb_divider_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/divider_seq_if.sv
// divider_seq_if: start/busy/done handshake, operands and results of the sequential divider.
interface divider_seq_if #(parameter int XWIDTH = 8, parameter int YWIDTH = 4);
  logic              start;
  logic [XWIDTH-1:0] x;
  logic [YWIDTH-1:0] y;
  logic              busy;
  logic              done;
  logic [XWIDTH-1:0] q;
  logic [YWIDTH-1:0] r;
  logic              dbz;
  modport master(output start, x, y, input busy, done, q, r, dbz);
  modport slave(input start, x, y, output busy, done, q, r, dbz);
endinterface

// File: rtl/divider_seq.sv
// divider_seq: restoring divider, one quotient bit per clock, with divide-by-zero flag.
// Define DIVIDER_SIGNED_EN for two's complement operands (truncating quotient, remainder follows dividend).
module divider_seq #(
  parameter int XWIDTH = 8,
  parameter int YWIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(XWIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [XWIDTH-1:0] r_x, r_q, w_xmag, w_qmag, w_qfix;
  logic [YWIDTH-1:0] r_y, r_rem, r_r, w_ymag, w_rem, w_rfix;
  logic              r_dbz, w_ge, w_accept, w_last;
  logic [YWIDTH:0]   w_shift;
  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(1));
  // dividend register doubles as the quotient shift register
  assign w_shift = {r_rem, r_x[XWIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_y};
  assign w_rem   = YWIDTH'(w_ge ? w_shift - {1'b0, r_y} : w_shift);
  assign w_qmag  = {r_x[XWIDTH-2:0], w_ge};
`ifdef DIVIDER_SIGNED_EN
  logic r_xneg, r_yneg;
  assign w_xmag = bus.x[XWIDTH-1] ? -bus.x : bus.x;
  assign w_ymag = bus.y[YWIDTH-1] ? -bus.y : bus.y;
  assign w_qfix = (r_xneg ^ r_yneg) ? -w_qmag : w_qmag;
  assign w_rfix = r_xneg ? -w_rem : w_rem;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_xneg <= 1'b0;
      r_yneg <= 1'b0;
    end else if (w_accept) begin
      r_xneg <= bus.x[XWIDTH-1];
      r_yneg <= bus.y[YWIDTH-1];
    end
`else
  assign w_xmag = bus.x;
  assign w_ymag = bus.y;
  assign w_qfix = w_qmag;
  assign w_rfix = w_rem;
`endif
  always_comb begin
    w_next   = (r_state == IDLE) ? (bus.start ? ((bus.y == '0) ? DONE : RUN) : IDLE) :
               (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    bus.busy = (r_state == RUN);
    bus.done = (r_state == DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_x   <= w_xmag;
        r_y   <= w_ymag;
        r_rem <= '0;
        r_cnt <= CW'(XWIDTH);
        if (bus.y == '0) begin
          r_q   <= '1;
          r_r   <= '0;
          r_dbz <= 1'b1;
        end
      end else if (r_state == RUN) begin
        r_x   <= w_qmag;
        r_rem <= w_rem;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) begin
          r_q   <= w_qfix;
          r_r   <= w_rfix;
          r_dbz <= 1'b0;
        end
      end
    end
  assign bus.q   = r_q;
  assign bus.r   = r_r;
  assign bus.dbz = r_dbz;
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed and exhaustive checks of divider_seq against a scoreboard of expected results.
module tb_divider_seq;
  localparam int XW = 8, YW = 4;
  typedef struct packed {logic [XW-1:0] q; logic [YW-1:0] r; logic dbz;} res_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int   errors = 0, checks = 0;
  res_t sb[$];
  res_t last;
  divider_seq_if #(.XWIDTH(XW), .YWIDTH(YW)) bus();
  divider_seq #(.XWIDTH(XW), .YWIDTH(YW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t mk(input logic [XW-1:0] q, input logic [YW-1:0] r, input logic dbz);
    mk = '{q: q, r: r, dbz: dbz};
  endfunction

  function automatic res_t pick(input res_t u, input res_t s);
`ifdef DIVIDER_SIGNED_EN
    pick = s;
`else
    pick = u;
`endif
  endfunction

  function automatic res_t model(input logic [XW-1:0] xv, input logic [YW-1:0] yv);
    int sx, sy, qi, ri;
    if (yv == '0) return mk('1, '0, 1'b1);
`ifdef DIVIDER_SIGNED_EN
    sx = int'($signed(xv));
    sy = int'($signed(yv));
`else
    sx = int'(xv);
    sy = int'(yv);
`endif
    qi = sx / sy;
    ri = sx % sy;
    return mk(XW'(qi), YW'(ri), 1'b0);
  endfunction

  task automatic start_op(input logic [XW-1:0] xv, input logic [YW-1:0] yv, input res_t e);
    @(negedge clk);
    check("done single pulse", bus.done, 1'b0);
    bus.x = xv;
    bus.y = yv;
    bus.start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x = XW'($urandom);
    bus.y = YW'($urandom);
  endtask

  task automatic wait_done(input string tag, input int lat0);
    int   lat, bc;
    res_t e;
    lat = lat0;
    bc  = 0;
    while (bus.done !== 1'b1 && lat < XW + 8) begin
      bc += int'(bus.busy === 1'b1);
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    check({tag, " latency"}, lat, e.dbz ? 1 : XW + 1);
    check({tag, " busy cycles"}, bc, e.dbz ? 0 : XW - (lat0 - 1));
    check({tag, " busy at done"}, bus.busy, 1'b0);
    check({tag, " q"}, bus.q, e.q);
    check({tag, " r"}, bus.r, e.r);
    check({tag, " dbz"}, bus.dbz, e.dbz);
    last = e;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    #12;
    check("reset q", bus.q, 0);
    check("reset r", bus.r, 0);
    check("reset dbz", bus.dbz, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'd200, 4'd7, pick(mk(8'd28, 4'd4, 1'b0), mk(8'hF8, 4'h0, 1'b0)));
    wait_done("200/7", 1);
    repeat (5) begin
      @(negedge clk);
      check("hold q", bus.q, last.q);
      check("hold r", bus.r, last.r);
      check("hold done", bus.done, 1'b0);
    end
    start_op(8'd255, 4'd15, pick(mk(8'd17, 4'd0, 1'b0), mk(8'd1, 4'd0, 1'b0)));
    wait_done("255/15", 1);
    start_op(8'd0, 4'd1, mk(8'd0, 4'd0, 1'b0));
    wait_done("b2b 0/1", 1);
    start_op(8'd13, 4'd0, mk(8'hFF, 4'd0, 1'b1));
    wait_done("13/0", 1);
    start_op(8'd9, 4'd3, mk(8'd3, 4'd0, 1'b0));
    wait_done("9/3", 1);
    start_op(8'd100, 4'd9, mk(8'd11, 4'd1, 1'b0));
    bus.x = 8'd1;
    bus.y = 4'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignored start", 2);
    start_op(8'd250, 4'd3, pick(mk(8'd83, 4'd1, 1'b0), mk(8'hFE, 4'd0, 1'b0)));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset q", bus.q, 0);
    check("midreset r", bus.r, 0);
    check("midreset dbz", bus.dbz, 0);
    check("midreset busy", bus.busy, 0);
    sb.delete();
    @(negedge clk);
    check("midreset done", bus.done, 0);
    rst_n = 1'b1;
    start_op(8'd250, 4'd3, pick(mk(8'd83, 4'd1, 1'b0), mk(8'hFE, 4'd0, 1'b0)));
    wait_done("250/3 after reset", 1);
`ifdef DIVIDER_SIGNED_EN
    start_op(8'h9C, 4'h7, mk(8'hF2, 4'hE, 1'b0));
    wait_done("-100/7", 1);
    start_op(8'h80, 4'hF, mk(8'h80, 4'h0, 1'b0));
    wait_done("-128/-1", 1);
`endif
    for (int xi = 0; xi < 256; xi++)
      for (int yi = 1; yi < 16; yi++) begin
        start_op(XW'(xi), YW'(yi), model(XW'(xi), YW'(yi)));
        wait_done("sweep", 1);
      end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
